// File: rtl/seg_scan_driver.sv
// Write-only 4-digit common-anode seven-segment scan driver fed by the decoder write demux.
// Define DISPLAY_BCD_EN to show the stored value in decimal through a double-dabble converter.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeEnable,
    input  logic [31:0] writeData,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             unused_hi;

    assign unused_hi = ^writeData[31:16];

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Refresh timing and one-cycle-lagged anode/segment drive; no blanking between digits.
    always_comb begin : scan_comb
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_q);
        seg_d = glyph(digit_q[idx_q]);
    end

    always_ff @(posedge clk or posedge rst) begin : scan_regs
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            an_q    <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

`ifdef DISPLAY_BCD_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] bcd_q, bcd_d, bcd_adj;
    logic [3:0]  step_q, step_d;
    logic        pend_q, pend_d;
    logic        busy_q, busy_d;
    logic        unused_bcd;

    assign unused_bcd = bcd_adj[19];

    function automatic logic [19:0] dabble_adj(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // A write during CONV is parked as pending; a write landing in LOAD restarts directly from writeData.
    always_comb begin : bcd_fsm_comb
        state_d = state_q;
        disp_d  = disp_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        pend_d  = pend_q;
        digit_d = digit_q;
        bcd_adj = dabble_adj(bcd_q);
        if (writeEnable) disp_d = writeData[15:0];
        case (state_q)
            S_IDLE: begin
                if (writeEnable) begin
                    shift_d = writeData[15:0];
                    bcd_d   = '0;
                    step_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (writeEnable) pend_d = 1'b1;
                bcd_d   = {bcd_adj[18:0], shift_q[15]};
                shift_d = {shift_q[14:0], 1'b0};
                step_d  = step_q + 4'd1;
                if (step_q == 4'd15) state_d = S_LOAD;
            end
            S_LOAD: begin
                digit_d = (bcd_q[19:16] != 4'd0) ? 16'h9999 : bcd_q[15:0];
                pend_d  = 1'b0;
                if (writeEnable || pend_q) begin
                    shift_d = writeEnable ? writeData[15:0] : disp_q;
                    bcd_d   = '0;
                    step_d  = '0;
                    state_d = S_CONV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin : bcd_regs
        if (rst) begin
            state_q <= S_IDLE;
            disp_q  <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    // Digit registers double as the display register in the hex build.
    always_comb begin : hex_comb
        digit_d = digit_q;
        if (writeEnable) digit_d = writeData[15:0];
    end

    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4; the BCD scenarios run when DISPLAY_BCD_EN is defined.
module tb_seg_scan_driver;
    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        writeEnable;
    logic [31:0] writeData;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [3:0] AN_EXP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

`ifdef DISPLAY_BCD_EN
    localparam int          RST_K   = 25;
    localparam logic [31:0] RST_VAL = 32'h0000_04D2;
`else
    localparam int          RST_K   = 9;
    localparam logic [31:0] RST_VAL = 32'h0000_1234;
`endif

    always #5 clk = ~clk;

    seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .writeEnable (writeEnable),
        .writeData   (writeData),
        .seg         (seg),
        .an          (an),
        .busy        (busy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; writeEnable = 1'b0; writeData = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; writeEnable = 1'b0; writeData = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_an: got %b want %b", an, 4'b1110); end
        n_cmp++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg: got %b want %b", seg, 7'b1000000); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL reset_first_edge_an: got %b want %b", an, 4'b1110); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        writeEnable = 1'b1; writeData = RST_VAL;
        @(negedge clk);
        writeEnable = 1'b0; writeData = '0;
        repeat (RST_K - 1) @(negedge clk);
        n_cmp++; if (an !== 4'b1011 || seg !== 7'b0100100) begin
            n_fail++; $display("FAIL midscan_pre: got an=%b seg=%b want an=1011 seg=0100100", an, seg);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (an !== 4'b1110) begin n_fail++; $display("FAIL midscan_an: got %b want 1110", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL midscan_seg: got %b want 1000000", seg); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midscan_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifndef DISPLAY_BCD_EN
    task automatic test_hex_scan();
        logic [6:0] exp_seg [4];
        int idx;
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        do_reset();
        writeEnable = 1'b1; writeData = 32'h0000_1234;
        @(negedge clk);
        writeEnable = 1'b0; writeData = '0;
        for (int k = 2; k <= 33; k++) begin
            @(negedge clk);
            idx = ((k - 1) / DIV) % 4;
            n_cmp++; if (an !== AN_EXP[idx] || seg !== exp_seg[idx]) begin
                n_fail++; $display("FAIL hex_scan k=%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, AN_EXP[idx], exp_seg[idx]);
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hex_busy: got %b want 0", busy); end
    endtask

    task automatic test_upper_ignored();
        logic [6:0] exp_seg [4];
        int idx;
        exp_seg = '{7'b0000000, 7'b0001000, 7'b1000000, 7'b1000000};
        do_reset();
        writeEnable = 1'b1; writeData = 32'hFFFF_00A8;
        @(negedge clk);
        writeEnable = 1'b0; writeData = '0;
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            idx = ((k - 1) / DIV) % 4;
            n_cmp++; if (an !== AN_EXP[idx] || seg !== exp_seg[idx]) begin
                n_fail++; $display("FAIL upper_ignored k=%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, AN_EXP[idx], exp_seg[idx]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_seg [4];
        int idx;
        exp_seg = '{7'b0000110, 7'b0010010, 7'b1000110, 7'b0010000};
        do_reset();
        writeEnable = 1'b1; writeData = 32'h0000_7777;
        @(negedge clk);
        writeData = 32'h0000_9C5E;
        @(negedge clk);
        writeEnable = 1'b0; writeData = '0;
        for (int k = 3; k <= 17; k++) begin
            @(negedge clk);
            idx = ((k - 1) / DIV) % 4;
            n_cmp++; if (an !== AN_EXP[idx] || seg !== exp_seg[idx]) begin
                n_fail++; $display("FAIL back_to_back k=%0d: got an=%b seg=%b want an=%b seg=%b", k, an, seg, AN_EXP[idx], exp_seg[idx]);
            end
        end
    endtask
`else
    task automatic test_bcd_1234();
        logic [6:0] exp_seg [4];
        int idx;
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        do_reset();
        writeEnable = 1'b1; writeData = 32'h0000_04D2;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            writeEnable = 1'b0; writeData = '0;
            idx = ((k - 1) / DIV) % 4;
            n_cmp++; if (busy !== (k <= 17)) begin n_fail++; $display("FAIL bcd1234_busy k=%0d: got %b want %b", k, busy, (k <= 17)); end
            n_cmp++; if (seg !== ((k <= 18) ? 7'b1000000 : exp_seg[idx])) begin
                n_fail++; $display("FAIL bcd1234_seg k=%0d: got %b want %b", k, seg, (k <= 18) ? 7'b1000000 : exp_seg[idx]);
            end
        end
    endtask

    task automatic test_bcd_saturate();
        do_reset();
        writeEnable = 1'b1; writeData = 32'h0000_FFFF;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            writeEnable = 1'b0; writeData = '0;
            n_cmp++; if (busy !== (k <= 17)) begin n_fail++; $display("FAIL bcdsat_busy k=%0d: got %b want %b", k, busy, (k <= 17)); end
            n_cmp++; if (seg !== ((k <= 18) ? 7'b1000000 : 7'b0010000)) begin
                n_fail++; $display("FAIL bcdsat_seg k=%0d: got %b want %b", k, seg, (k <= 18) ? 7'b1000000 : 7'b0010000);
            end
        end
    endtask

    task automatic test_bcd_pending();
        logic [6:0] seg5 [4];
        logic [6:0] seg42 [4];
        logic [6:0] want;
        int idx;
        seg5  = '{7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000};
        seg42 = '{7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000};
        do_reset();
        writeEnable = 1'b1; writeData = 32'd5;
        for (int k = 1; k <= 51; k++) begin
            @(negedge clk);
            writeEnable = (k == 3);
            writeData   = (k == 3) ? 32'd42 : 32'd0;
            idx = ((k - 1) / DIV) % 4;
            want = (k <= 18) ? 7'b1000000 : (k <= 35) ? seg5[idx] : seg42[idx];
            n_cmp++; if (busy !== (k <= 34)) begin n_fail++; $display("FAIL bcdpend_busy k=%0d: got %b want %b", k, busy, (k <= 34)); end
            n_cmp++; if (seg !== want) begin n_fail++; $display("FAIL bcdpend_seg k=%0d: got %b want %b", k, seg, want); end
        end
    endtask

    task automatic test_bcd_abort();
        do_reset();
        writeEnable = 1'b1; writeData = 32'h0000_04D2;
        repeat (5) @(negedge clk);
        writeEnable = 1'b0; writeData = '0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || seg !== 7'b1000000) begin
            n_fail++; $display("FAIL abort_after: got busy=%b seg=%b want busy=0 seg=1000000", busy, seg);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; writeEnable = 1'b0; writeData = '0;
        test_reset();
        test_reset_mid_scan();
`ifndef DISPLAY_BCD_EN
        test_hex_scan();
        test_upper_ignored();
        test_back_to_back();
`else
        test_bcd_1234();
        test_bcd_saturate();
        test_bcd_pending();
        test_bcd_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Memory-mapped output peripheral that sits directly downstream of the address decoder's write demux. It consumes writeData when the LED/display write enable is strobed and holds the value in a display register. It time-multiplexes the value onto a 4-digit common-anode seven-segment display on the board.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range >= 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
writeEnable  input  1  display write strobe from decoder demux; sampled on rising edge
writeData  input  32  store data; only bits [15:0] used
seg  output  7  segment drive, active low; seg[0]=a … seg[6]=g; registered
an  output  4  anode enables, active low; an[0]=rightmost (least-significant) digit; registered
busy  output  1  conversion in progress (BCD build only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1): dispReg=0; digit regs=0; refresh counter=0; digit index=0; an=4'b1110; seg=7'b1000000 (glyph "0"); busy=0; FSM=IDLE.
- Capture: writeEnable=1 at edge N loads writeData[15:0] into dispReg. writeData[31:16] is ignored. readEnable does not exist; the block is write-only.
- Hex build (macro absent): digit regs = dispReg nibbles, loaded on the same edge N. digit0 = [3:0] … digit3 = [15:12].
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, the digit index increments 0→1→2→3→0.
- Output registers update every edge from the current index and digit regs, with a 1-cycle lag:
  - an = ~(4'b0001 << idx)
  - seg = glyph(digit[idx])
  - Exactly one anode is low at all times after reset.
- Glyph table (active low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Latency (hex): write at edge N; the new glyph is on seg by edge N+1 if that digit is currently selected.
- Writes do not disturb the refresh counter or index. There is no blanking between digits.
- Back-to-back writes: last write wins; every write is accepted.

Optional Feature:
DISPLAY_BCD_EN
- Defined: the display shows dispReg as unsigned decimal.
- FSM states:
  - IDLE: a capture loads the shifter with dispReg and goes to CONV.
  - CONV: 16 cycles of shift-add-3 double dabble on a 20-bit BCD accumulator.
  - LOAD: 1 cycle. Copies the four low BCD digits into the digit regs. If BCD digit4 ≠ 0 (value > 9999), loads 9,9,9,9 instead (saturate). Then goes to IDLE, or back to CONV if a write is pending.
- busy=1 in CONV and LOAD.
- Latency: write at edge N; digit regs update at edge N+17; seg reflects at N+18.
- Write while busy: value goes into dispReg with a pending flag (depth 1, last-write-wins). The current conversion completes and loads, then the pending value converts immediately.
- Reset mid-conversion aborts to IDLE with all outputs at reset values.
- Undefined: hex behaviour as above, busy=0, no FSM.

Test Plan:
1. Reset mid-scan (idx=2, REFRESH_DIV=4) → an=1110, seg=1000000, busy=0 asynchronously, before the next edge.
2. Hex, REFRESH_DIV=4, write 0x00001234 → an sequence 1110,1101,1011,0111, 4 cycles each, seg 0011001,0110000,0100100,1111001 respectively; sequence repeats.
3. Hex, write 0xFFFF00A8 → digits 8,A,0,0 (seg 0000000,0001000,1000000,1000000); upper half has no effect.
4. BCD, write 0x000004D2 → busy=1 for exactly 17 cycles, then digits 4,3,2,1 displayed ("1234").
5. BCD, write 0x0000FFFF → after 17 cycles all four digits show 0010000 ("9999").
6. BCD, write 5, then write 42 three cycles later (during busy) → "0005" loads at N+17; busy stays high; "0042" loads 17 cycles later; busy then drops.
